// File: rtl/pipe_sched_pkg.sv
// rtl/pipe_sched_pkg.sv - shared types and constants for the stall scheduler
package pipe_sched_pkg;

  localparam int StallW = 6;
  localparam int CntW   = 6;
  localparam int StageId = 2;

  typedef logic [StallW-1:0] stall_bus_t;

  localparam logic Stop   = 1'b1;
  localparam logic NoStop = 1'b0;

  typedef enum logic [1:0] {
    MdIdle = 2'd0,
    MdBusy = 2'd1,
    MdDone = 2'd2
  } md_state_e;

  localparam stall_bus_t StallMd   = 6'b001111;
  localparam stall_bus_t StallLoad = 6'b000111;
  localparam stall_bus_t StallBru  = 6'b000011;
  localparam stall_bus_t StallNone = 6'b000000;

  // Counter preload is LAT-1 so the BUSY phase lasts exactly LAT cycles.
  function automatic logic [CntW-1:0] md_load_val(input logic is_div,
                                                  input int mul_lat,
                                                  input int div_lat);
    logic [CntW-1:0] mul_v;
    logic [CntW-1:0] div_v;
    mul_v = CntW'(mul_lat - 1);
    div_v = CntW'(div_lat - 1);
    return is_div ? div_v : mul_v;
  endfunction

endpackage

// File: rtl/md_timer.sv
// rtl/md_timer.sv - loadable 6-bit down-counter with zero flag
module md_timer
  import pipe_sched_pkg::*;
(
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            load_i,
  input  logic [CntW-1:0] load_val_i,
  input  logic            dec_i,
  output logic            zero_o
);

  logic [CntW-1:0] cnt_q, cnt_d;

  // Decrement saturates at zero; load takes priority.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/pipe_sched.sv
// rtl/pipe_sched.sv - pipeline stall merge and mul/div start/busy/ready sequencer
module pipe_sched
  import pipe_sched_pkg::*;
#(
  parameter int MUL_LAT = 2,
  parameter int DIV_LAT = 32
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       stallreq_for_load_i,
  input  logic       stallreq_for_bru_i,
  input  logic       md_req_i,
  input  logic       md_is_div_i,
  output stall_bus_t stall_o,
  output logic       md_start_o,
  output logic       md_busy_o,
  output logic       md_ready_o
);

  md_state_e state_q, state_d;
  logic      lu_taken_q, lu_taken_d;
  logic      timer_load, timer_dec, timer_zero;
  logic      md_stall, load_req, idle_req;
  logic [CntW-1:0] timer_val;

  assign timer_val = md_load_val(md_is_div_i, MUL_LAT, DIV_LAT);

  md_timer u_md_timer (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .load_i     (timer_load),
    .load_val_i (timer_val),
    .dec_i      (timer_dec),
    .zero_o     (timer_zero)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= MdIdle;
      lu_taken_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      lu_taken_q <= lu_taken_d;
    end
  end

  // md_req is deliberately ignored in DONE so one instruction cannot relaunch.
  always_comb begin
    state_d    = state_q;
    timer_load = 1'b0;
    timer_dec  = 1'b0;
    case (state_q)
      MdIdle: begin
        if (md_req_i) begin
          timer_load = 1'b1;
          state_d    = MdBusy;
        end
      end
      MdBusy: begin
        if (timer_zero) begin
          state_d = MdDone;
        end else begin
          timer_dec = 1'b1;
        end
      end
      MdDone:  state_d = MdIdle;
      default: state_d = MdIdle;
    endcase
  end

  assign idle_req   = (state_q == MdIdle) && md_req_i;
  assign md_stall   = !rst_i && (idle_req || (state_q == MdBusy));
  assign md_start_o = !rst_i && idle_req;
  assign md_busy_o  = !rst_i && (state_q == MdBusy);
  assign md_ready_o = !rst_i && (state_q == MdDone);

  assign load_req = !rst_i && stallreq_for_load_i && !lu_taken_q;

  always_comb begin
    stall_o = StallNone;
    if (rst_i) begin
      stall_o = StallNone;
    end else if (md_stall) begin
      stall_o = StallMd;
    end else if (load_req) begin
      stall_o = StallLoad;
    end else if (stallreq_for_bru_i) begin
      stall_o = StallBru;
    end
  end

  // The flag survives as long as ID is held, so a dominated load is never lost.
  always_comb begin
    lu_taken_d = lu_taken_q;
    if (stall_o[StageId] == NoStop) begin
      lu_taken_d = 1'b0;
    end else if (load_req && !md_stall) begin
      lu_taken_d = 1'b1;
    end
  end

endmodule
